// File: rtl/common.sv
// Shared cache-bus types: request/response structs, size/len/burst enums,
// word type, and the burst arbiter state encoding (visible to benches).
package common;

  typedef logic [63:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Burst length encoded as beats-1, AXI style.
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    msize_t     size;
    addr_t      addr;
    strobe_t    strobe;
    word_t      data;
    mlen_t      len;
    axi_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  // Burst arbiter FSM encoding.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cbus_arb_select.sv
// Combinational winner selection for the cache-bus burst arbiter.
// Build option CBUS_ARB_ROUND_ROBIN_EN: search starts at rr_ptr and wraps;
// otherwise the lowest valid index wins and rr_ptr is ignored.
module cbus_arb_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  assign any_valid = |valid;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  // Scan from the farthest slot back to rr_ptr so the first valid slot at or after rr_ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (valid[idx]) begin
        winner = IDX_W'(idx);
      end
    end
  end
`else
  // Fixed priority: scan high to low so the lowest valid index is the last write.
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[k]) begin
        winner = IDX_W'(k);
      end
    end
  end

  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
`endif

endmodule

// File: rtl/cbus_burst_arbiter.sv
// Cache-bus burst arbiter: grants one requester for a whole burst, holds the
// grant until oresp.ready && oresp.last, then always spends one IDLE cycle
// before the next grant. Request/response paths are pure muxes on the grant.
// Build option CBUS_ARB_ROUND_ROBIN_EN: round-robin instead of fixed priority.
// NUM_REQ must be at least 2.
module cbus_burst_arbiter
  import common::*;
#(
  parameter int  NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  arb_state_t       state_reg;
  logic [IDX_W-1:0] grant_idx_reg;
  logic             busy_reg;
  logic [IDX_W-1:0] rr_ptr_sel;
  logic [NUM_REQ-1:0] req_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_valid
      assign req_valid[gi] = ireqs[gi].valid;
    end
  endgenerate

  cbus_arb_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_select (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_sel),
    .winner    (sel_idx),
    .any_valid (sel_any)
  );

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_reg;
  assign rr_ptr_sel = rr_ptr_reg;

  // Advance the round-robin pointer past the requester whose burst just finished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= '0;
    end else if (state_reg == BUSY && oresp.ready && oresp.last) begin
      rr_ptr_reg <= (grant_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;
    end
  end
`else
  assign rr_ptr_sel = '0;
`endif

  // Arbitration FSM: latch the winner in IDLE, release on the last ready beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_any) begin
            grant_idx_reg <= sel_idx;
            state_reg     <= BUSY;
            busy_reg      <= 1'b1;
          end
        end
        BUSY: begin
          if (oresp.ready && oresp.last) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Forward the granted request unchanged while a burst is open.
  always_comb begin
    oreq = '0;
    if (state_reg == BUSY) begin
      oreq = ireqs[grant_idx_reg];
    end
  end

  // Route the memory response to the granted requester only.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      assign iresps[gi] = (state_reg == BUSY && grant_idx_reg == IDX_W'(gi)) ? oresp : '0;
    end
  endgenerate

  assign busy      = busy_reg;
  assign grant_idx = grant_idx_reg;

endmodule

// File: tb/tb_cbus_burst_arbiter.sv
// Directed bench for cbus_burst_arbiter: single burst, simultaneous requests,
// grant hold, spurious beat, asynchronous reset mid-burst, grant ordering.
module tb_cbus_burst_arbiter;
  import common::*;

  logic       clk;
  logic       reset;
  cbus_req_t  ireqs  [2];
  cbus_resp_t iresps [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] grant_idx;

  int checks = 0;
  int errors = 0;
  int exp_order [4];

  cbus_burst_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One memory beat to requester idx; the other requester must see nothing.
  task automatic beat(input int idx, input int b, input int n);
    oresp.ready = 1'b1;
    oresp.last  = (b == n);
    oresp.data  = 64'(b) + 64'h100;
    #1;
    chk($sformatf("beat%0d_rdy", b), 128'(iresps[idx].ready), 128'(1));
    chk($sformatf("beat%0d_data", b), 128'(iresps[idx].data), 128'(64'(b) + 64'h100));
    chk($sformatf("beat%0d_other", b), 128'(iresps[1-idx]), 128'(0));
    tick();
    oresp = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp = '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant_idx), 128'(0));
    chk("rst_oreq", 128'(oreq), 128'(0));
    chk("rst_iresp1", 128'(iresps[1]), 128'(0));
    chk("rst_state", 128'(dut.state_reg), 128'(IDLE));
    #2 reset = 1'b1;
    tick();

    // Single DCache read burst of 16 beats.
    ireqs[1].valid = 1'b1;
    ireqs[1].addr  = 32'h8000_0040;
    ireqs[1].len   = MLEN16;
    ireqs[1].size  = MSIZE8;
    ireqs[1].burst = AXI_BURST_INCR;
    #1;
    chk("t1_lat0_valid", 128'(oreq.valid), 128'(0));
    tick();
    chk("t1_oreq_valid", 128'(oreq.valid), 128'(1));
    chk("t1_oreq_addr", 128'(oreq.addr), 128'(32'h8000_0040));
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_grant", 128'(grant_idx), 128'(1));
    for (int b = 1; b <= 16; b++) beat(1, b, 16);
    ireqs[1] = '0;
    #1;
    chk("t1_busy_fall", 128'(busy), 128'(0));
    chk("t1_oreq_idle", 128'(oreq.valid), 128'(0));
    $display("burst requester=1 beats=16 addr=80000040");

    // Spurious memory beat while idle.
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'h55;
    #1;
    chk("sp_iresp0", 128'(iresps[0]), 128'(0));
    chk("sp_iresp1", 128'(iresps[1]), 128'(0));
    tick();
    chk("sp_state", 128'(dut.state_reg), 128'(IDLE));
    chk("sp_busy", 128'(busy), 128'(0));
    oresp = '0;
    $display("spurious beat while idle ignored");

    // Simultaneous read (0) and write (1).
    ireqs[0].valid = 1'b1;
    ireqs[0].addr  = 32'h0000_1000;
    ireqs[0].len   = MLEN16;
    ireqs[1].valid    = 1'b1;
    ireqs[1].is_write = 1'b1;
    ireqs[1].addr     = 32'h0000_2000;
    ireqs[1].len      = MLEN16;
    ireqs[1].strobe   = 8'hFF;
    ireqs[1].data     = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    chk("t2_grant0", 128'(grant_idx), 128'(0));
    chk("t2_addr0", 128'(oreq.addr), 128'(32'h0000_1000));
    chk("t2_wr0", 128'(oreq.is_write), 128'(0));
    for (int b = 1; b <= 16; b++) beat(0, b, 16);
    ireqs[0] = '0;
    #1;
    chk("t2_bubble_busy", 128'(busy), 128'(0));
    chk("t2_bubble_valid", 128'(oreq.valid), 128'(0));
    $display("burst requester=0 beats=16 addr=00001000");
    tick();
    chk("t2_grant1", 128'(grant_idx), 128'(1));
    chk("t2_wdata", 128'(oreq.data), 128'(64'hDEAD_BEEF_CAFE_F00D));
    chk("t2_strobe", 128'(oreq.strobe), 128'(8'hFF));
    chk("t2_wr1", 128'(oreq.is_write), 128'(1));
    for (int b = 1; b <= 16; b++) beat(1, b, 16);
    $display("burst requester=1 beats=16 write");

    // Same requester stays valid: bubble, then grant hold against index 0.
    #1;
    chk("t3_bubble_busy", 128'(busy), 128'(0));
    tick();
    chk("t3_grant1", 128'(grant_idx), 128'(1));
    for (int b = 1; b <= 16; b++) begin
      if (b == 5) begin
        ireqs[0].valid = 1'b1;
        ireqs[0].addr  = 32'h0000_3000;
        ireqs[0].len   = MLEN16;
      end
      beat(1, b, 16);
    end
    ireqs[1] = '0;
    #1;
    chk("t3_bubble_busy2", 128'(busy), 128'(0));
    chk("t3_bubble_iresp0", 128'(iresps[0]), 128'(0));
    $display("burst requester=1 beats=16 held against requester 0");
    tick();
    chk("t3_grant0", 128'(grant_idx), 128'(0));
    chk("t3_addr0", 128'(oreq.addr), 128'(32'h0000_3000));

    // Asynchronous reset at beat 7 of index 0's burst.
    for (int b = 1; b <= 6; b++) beat(0, b, 16);
    oresp.ready = 1'b1;
    oresp.data  = 64'h7;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(oreq.valid), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_iresp0", 128'(iresps[0]), 128'(0));
    chk("rst_mid_iresp1", 128'(iresps[1]), 128'(0));
    ireqs[0] = '0;
    oresp = '0;
    #1;
    reset = 1'b1;
    ireqs[1].valid = 1'b1;
    ireqs[1].len   = MLEN1;
    $display("reset asserted at beat 7 of requester 0");
    tick();
    chk("post_rst_grant", 128'(grant_idx), 128'(1));
    chk("post_rst_busy", 128'(busy), 128'(1));
    beat(1, 1, 1);
    chk("post_rst_idle", 128'(busy), 128'(0));
    $display("burst requester=1 beats=1 after reset");

    // Both requesters continuously valid, single-beat bursts.
    ireqs[0].valid = 1'b1;
    ireqs[0].len   = MLEN1;
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("rr%0d_bubble", r), 128'(busy), 128'(0));
      tick();
      chk($sformatf("rr%0d_grant", r), 128'(grant_idx), 128'(exp_order[r]));
      $display("burst %0d requester=%0d beats=1", r, grant_idx);
      beat(exp_order[r], 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
